// File: rtl/reg_value_fwd1_if.sv
// Bundle of the forwarding unit's request, writer, result and statistics signals.
// The master side supplies the read request and in-flight writer; the slave is the bypass unit.
interface reg_value_fwd1_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic [REG_W-1:0]  ReadRegister1;
    logic [DATA_W-1:0] RegisterData1;
    logic [REG_W-1:0]  WriteRegister1stPri1;
    logic [DATA_W-1:0] WriteData1stPri1;
    logic              Valid1stPri1;
    logic              comment;
    logic [DATA_W-1:0] Output1;
    logic              Forwarded;
    logic [CNT_W-1:0]  Fwd_count;
    logic [REG_W-1:0]  Last_fwd_reg;

    // No handshake: the result is a pure function of the current request and writer.
    modport master (
        output ReadRegister1, RegisterData1, WriteRegister1stPri1,
               WriteData1stPri1, Valid1stPri1, comment,
        input  Output1, Forwarded, Fwd_count, Last_fwd_reg
    );

    modport slave (
        input  ReadRegister1, RegisterData1, WriteRegister1stPri1,
               WriteData1stPri1, Valid1stPri1, comment,
        output Output1, Forwarded, Fwd_count, Last_fwd_reg
    );
endinterface

// File: rtl/reg_value_fwd1.sv
// Single-source register-value bypass: substitutes the youngest writer's data for a stale
// register read; keeps a saturating forward counter and the last forwarded register number.
module reg_value_fwd1 #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input logic            CLK,
    input logic            RESET,
    reg_value_fwd1_if.slave bus
);
    logic              forwarded;
    logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;
    logic [REG_W-1:0]  last_fwd_reg_q, last_fwd_reg_d;

    // Register 0 is hardwired to zero in MIPS, so a writer targeting it must never win.
    always_comb begin
        forwarded = bus.Valid1stPri1
                 && (bus.WriteRegister1stPri1 == bus.ReadRegister1)
                 && (bus.ReadRegister1 != '0);
    end

    assign bus.Forwarded    = forwarded;
    assign bus.Output1      = forwarded ? bus.WriteData1stPri1 : bus.RegisterData1;
    assign bus.Fwd_count    = fwd_count_q;
    assign bus.Last_fwd_reg = last_fwd_reg_q;

    always_comb begin
        fwd_count_d    = fwd_count_q;
        last_fwd_reg_d = last_fwd_reg_q;
        if (forwarded) begin
            last_fwd_reg_d = bus.ReadRegister1;
            if (fwd_count_q != '1) begin
                fwd_count_d = fwd_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fwd_count_q    <= '0;
            last_fwd_reg_q <= '0;
        end else begin
            fwd_count_q    <= fwd_count_d;
            last_fwd_reg_q <= last_fwd_reg_d;
        end
    end

`ifndef SYNTHESIS
    // Debug trace only; has no effect on the data path or statistics.
    always @(posedge CLK) begin
        if (bus.comment) begin
            $display("fwd trace: rd=%0d rdata=%h wr=%0d wdata=%h valid=%b out=%h",
                     bus.ReadRegister1, bus.RegisterData1, bus.WriteRegister1stPri1,
                     bus.WriteData1stPri1, bus.Valid1stPri1, bus.Output1);
        end
    end
`endif
endmodule

// File: tb/tb_reg_value_fwd1.sv
// Scoreboard bench for reg_value_fwd1: directed vectors push expected results into a queue,
// a monitor pops and compares on every falling clock edge.
module tb_reg_value_fwd1;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  // clock / reset
  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  reg_value_fwd1_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW))  bus ();
  reg_value_fwd1_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW4)) bus4 ();

  reg_value_fwd1 #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  reg_value_fwd1 #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW4)) dut4 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus4.slave)
  );

  typedef struct packed {
    logic [DW-1:0]  out;
    logic           fwd;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  last;
    logic [CW4-1:0] cnt4;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  // reference statistics model
  logic [CW-1:0]  m_cnt  = '0;
  logic [CW4-1:0] m_cnt4 = '0;
  logic [RW-1:0]  m_last = '0;
  logic           cur_fwd = 1'b0;
  logic [RW-1:0]  cur_rd  = '0;
  logic           trace_on = 1'b0;

  initial begin
    bus.ReadRegister1 = '0;  bus.RegisterData1 = '0;  bus.WriteRegister1stPri1 = '0;
    bus.WriteData1stPri1 = '0;  bus.Valid1stPri1 = 1'b0;  bus.comment = 1'b0;
    bus4.ReadRegister1 = '0; bus4.RegisterData1 = '0; bus4.WriteRegister1stPri1 = '0;
    bus4.WriteData1stPri1 = '0; bus4.Valid1stPri1 = 1'b0; bus4.comment = 1'b0;
  end

  // driver: after each rising edge, advance the model, then apply the next vector
  task automatic step(input string nm, input logic [RW-1:0] rd, input logic [DW-1:0] rdata,
                      input logic [RW-1:0] wr, input logic [DW-1:0] wdata, input logic v,
                      input logic rst, input logic [DW-1:0] exp_out, input logic exp_fwd);
    exp_t e;
    @(posedge CLK);
    if (RESET && cur_fwd) begin
      if (m_cnt  != '1) m_cnt  = m_cnt  + 1'b1;
      if (m_cnt4 != '1) m_cnt4 = m_cnt4 + 1'b1;
      m_last = cur_rd;
    end
    #2;
    RESET = rst;
    bus.ReadRegister1  = rd;  bus.RegisterData1  = rdata; bus.WriteRegister1stPri1  = wr;
    bus.WriteData1stPri1  = wdata; bus.Valid1stPri1  = v; bus.comment  = trace_on;
    bus4.ReadRegister1 = rd;  bus4.RegisterData1 = rdata; bus4.WriteRegister1stPri1 = wr;
    bus4.WriteData1stPri1 = wdata; bus4.Valid1stPri1 = v; bus4.comment = 1'b0;
    if (!rst) begin
      m_cnt = '0; m_cnt4 = '0; m_last = '0;
    end
    cur_fwd = exp_fwd;
    cur_rd  = rd;
    e.out = exp_out; e.fwd = exp_fwd; e.cnt = m_cnt; e.last = m_last; e.cnt4 = m_cnt4;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input string fld, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "Output1",      bus.Output1,                   e.out);
        chk(nm, "Forwarded",    {{(DW-1){1'b0}}, bus.Forwarded}, {{(DW-1){1'b0}}, e.fwd});
        chk(nm, "Fwd_count",    {{(DW-CW){1'b0}}, bus.Fwd_count}, {{(DW-CW){1'b0}}, e.cnt});
        chk(nm, "Last_fwd_reg", {{(DW-RW){1'b0}}, bus.Last_fwd_reg}, {{(DW-RW){1'b0}}, e.last});
        chk(nm, "Fwd_count4",   {{(DW-CW4){1'b0}}, bus4.Fwd_count}, {{(DW-CW4){1'b0}}, e.cnt4});
      end
    end
  end

  // stimulus
  initial begin
    step("reset",    5'd5, 32'h11111111, 5'd6, 32'h22222222, 1'b1, 1'b0, 32'h11111111, 1'b0);
    step("release",  5'd5, 32'h11111111, 5'd6, 32'h22222222, 1'b1, 1'b1, 32'h11111111, 1'b0);
    step("no_hit",   5'd5, 32'h11111111, 5'd6, 32'h22222222, 1'b1, 1'b1, 32'h11111111, 1'b0);
    trace_on = 1'b1;
    step("hit",      5'd5, 32'h11111111, 5'd5, 32'hCAFEDEAD, 1'b1, 1'b1, 32'hCAFEDEAD, 1'b1);
    trace_on = 1'b0;
    step("invalid",  5'd5, 32'h11111111, 5'd5, 32'hCAFEDEAD, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step("reg_zero", 5'd0, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b0);
    step("hit31",    5'd31, 32'h0BADF00D, 5'd31, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 1'b1);
    step("miss_low", 5'd1, 32'hA5A5A5A5, 5'd2, 32'h5A5A5A5A, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("sat",    5'd7, 32'h00000007, 5'd7, 32'h77777777, 1'b1, 1'b1, 32'h77777777, 1'b1);
    end
    step("sat_end",  5'd9, 32'h00000009, 5'd3, 32'h33333333, 1'b1, 1'b1, 32'h00000009, 1'b0);
    step("rst_clr",  5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("rst_rel",  5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("pre_rst", 5'd12, 32'hDEAD0000, 5'd12, 32'hBEEF000C, 1'b1, 1'b1, 32'hBEEF000C, 1'b1);
    end
    step("async_rst", 5'd12, 32'hDEAD0000, 5'd12, 32'hBEEF000C, 1'b1, 1'b0, 32'hBEEF000C, 1'b1);
    step("rst_held",  5'd12, 32'hDEAD0000, 5'd12, 32'hBEEF000C, 1'b1, 1'b0, 32'hBEEF000C, 1'b1);
    step("post_rst",  5'd12, 32'hDEAD0000, 5'd12, 32'hBEEF000C, 1'b1, 1'b1, 32'hBEEF000C, 1'b1);
    step("one_hit",   5'd4, 32'h44444444, 5'd8, 32'h88888888, 1'b1, 1'b1, 32'h44444444, 1'b0);
    step("idle",      5'd4, 32'h44444444, 5'd8, 32'h88888888, 1'b0, 1'b1, 32'h44444444, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_value_fwd1.md
# reg_value_fwd1

Single-source register-value forwarding (bypass) unit for the MIPS pipeline. Given a source register number and the value read for it upstream, it substitutes the result a later pipeline stage is about to write to that register, so the consumer (e.g. MEM store data) sees the newest value. The data path is purely combinational. A small clocked block keeps forwarding statistics and an optional debug trace.

## Interface
Parameters:
- DATA_W, 32, width of register data.
- REG_W, 5, width of register numbers.
- CNT_W, 16, width of the forward-hit counter.

Ports:
- CLK  in  1  clock; statistics registers update on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ReadRegister1  in  REG_W  register number whose value is requested.
- RegisterData1  in  DATA_W  value of ReadRegister1 as read upstream (possibly stale).
- WriteRegister1stPri1  in  REG_W  destination register of the first-priority (youngest) in-flight writer.
- WriteData1stPri1  in  DATA_W  data that writer will write.
- Valid1stPri1  in  1  the first-priority writer really writes its register.
- comment  in  1  enables the per-cycle $display trace.
- Output1  out  DATA_W  forwarded value.
- Forwarded  out  1  combinational; Output1 currently comes from WriteData1stPri1.
- Fwd_count  out  CNT_W  registered, saturating count of cycles with Forwarded=1.
- Last_fwd_reg  out  REG_W  registered; register number of the most recent forward.

## Operation
- Hit condition: Forwarded = Valid1stPri1 AND (WriteRegister1stPri1 == ReadRegister1) AND (ReadRegister1 != 0).
- Output1 = Forwarded ? WriteData1stPri1 : RegisterData1.
- Register 0 is never forwarded. Reads of register 0 pass RegisterData1 through unchanged, even if a valid writer targets register 0.
- Output1 and Forwarded are combinational. They respond in the same delta to any input change, with no clock dependence. They are unaffected by RESET.
- Statistics, on each rising CLK edge when RESET=1:
  - If Forwarded=1, Fwd_count increments by 1 and saturates at all-ones (no wrap).
  - If Forwarded=1, Last_fwd_reg <= ReadRegister1. Otherwise it holds.
- Debug trace: when comment=1, each rising CLK edge prints ReadRegister1, RegisterData1, WriteRegister1stPri1, WriteData1stPri1, Valid1stPri1 and Output1. When comment=0 nothing is printed. The trace has no functional effect.

## Timing
- Data path latency: 0 cycles (combinational).
- Statistics latency: 1 cycle. A forward at edge N is visible in Fwd_count and Last_fwd_reg after edge N.
- Reset values (RESET=0, asynchronous): Fwd_count=0, Last_fwd_reg=0. Both are held while RESET=0.
- Reset asserted mid-operation: the counters clear immediately, without waiting for CLK. Output1 and Forwarded keep tracking their inputs.
- Reset release: counting resumes at the first rising edge with RESET=1.
- Simultaneous events:
  - The writer's register matches, but Valid1stPri1=0: no forward.
  - Inputs change between edges: Output1 follows immediately. Statistics sample only the values present at the edge.

## Test plan
- No hit: Read=5, RegData=0x11111111, WrReg=6, WrData=0x22222222, Valid=1 -> Output1=0x11111111, Forwarded=0, Fwd_count unchanged after the edge.
- Hit: Read=5, RegData=0x11111111, WrReg=5, WrData=0xCAFEDEAD, Valid=1 -> Output1=0xCAFEDEAD and Forwarded=1 combinationally. After the edge, Fwd_count=1 and Last_fwd_reg=5.
- Invalid writer: same as the hit case but Valid=0 -> Output1=0x11111111, Forwarded=0.
- Register zero: Read=0, WrReg=0, Valid=1, RegData=0x0, WrData=0xFFFFFFFF -> Output1=0x0, Forwarded=0.
- Saturation: CNT_W=4, hold a hit for 20 edges -> Fwd_count reaches 15 and stays at 15.
- Async reset mid-run: after 3 hits, drive RESET=0 between edges -> Fwd_count=0 and Last_fwd_reg=0 immediately, while Output1 still shows the forwarded value. Release RESET, one more hit -> Fwd_count=1.
